// File: rtl/design_40_arb_pkg.sv
// Shared types and helpers for the design_40 round-robin arbiter.
package design_40_arb_pkg;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} arb_state_e;

  localparam int LAT_MAX = 4;

  function automatic int id_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/design_40_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping mod N.
module design_40_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = IDW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/design_40_arb.sv
// Shares one design_40 datapath between N requesters: round-robin issue,
// ID tag pipeline matching the datapath latency, and a drain/halt sequence.
module design_40_arb
  import design_40_arb_pkg::*;
#(
  parameter int W   = 8,
  parameter int N   = 4,
  parameter int LAT = 1,
  parameter int IDW = id_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [W-1:0]   dp_a,
  output logic [W-1:0]   dp_b,
  output logic           dp_start,
  input  logic [W-1:0]   dp_y,
  output logic           rsp_valid,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   rsp_y,
  input  logic           drain_req,
  output logic           drain_done,
  output logic           busy
);

  if (LAT < 1 || LAT > LAT_MAX) begin : g_lat_chk
    $error("design_40_arb: LAT out of range");
  end

  arb_state_e                state;
  logic [IDW-1:0]            rr_ptr;
  logic [LAT-1:0]            tag_vld;
  logic [LAT-1:0][IDW-1:0]   tag_id;
  logic [LAT-1:0]            tag_vld_sh;

  logic [N-1:0]              pick_grant;
  logic [IDW-1:0]            pick_idx;
  logic                      pick_any;
  logic                      issue_ok;
  logic                      xfer;
  logic                      pipe_clear_next;
  logic [IDW-1:0]            sel;
  logic [N-1:0][W-1:0]       a_vec;
  logic [N-1:0][W-1:0]       b_vec;

  design_40_rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // drain_req blocks issue in the very cycle it is first seen
  assign issue_ok  = (state == RUN) && !drain_req && !rst;
  assign req_ready = issue_ok ? pick_grant : '0;
  assign xfer      = issue_ok && pick_any;

  assign a_vec    = req_a;
  assign b_vec    = req_b;
  assign sel      = xfer ? pick_idx : rr_ptr;
  assign dp_a     = a_vec[sel];
  assign dp_b     = b_vec[sel];
  assign dp_start = xfer;

  assign rsp_valid = tag_vld[LAT-1] && !rst;
  assign rsp_id    = tag_id[LAT-1];
  assign rsp_y     = dp_y;
  assign busy      = (|tag_vld) || (|req_valid);

  // Pipe is empty after this edge if nothing issues and only the last stage
  // (retiring now) may be occupied; HALT is entered exactly when it empties.
  assign tag_vld_sh      = tag_vld << 1;
  assign pipe_clear_next = (tag_vld_sh == '0) && !xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= xfer;
      for (int s = 1; s < LAT; s++) tag_vld[s] <= tag_vld[s-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_id[0] <= pick_idx;
    for (int s = 1; s < LAT; s++) tag_id[s] <= tag_id[s-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      rr_ptr     <= '0;
      drain_done <= 1'b0;
    end else begin
      if (xfer) rr_ptr <= (pick_idx == IDW'(N-1)) ? '0 : pick_idx + 1'b1;
      case (state)
        RUN: if (drain_req) begin
          state      <= pipe_clear_next ? HALT : DRAIN;
          drain_done <= pipe_clear_next;
        end
        DRAIN: if (pipe_clear_next) begin
          state      <= HALT;
          drain_done <= 1'b1;
        end
        HALT: if (!drain_req) begin
          state      <= RUN;
          drain_done <= 1'b0;
        end
        default: begin
          state      <= RUN;
          drain_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_design_40_arb.sv
// Scoreboard bench for design_40_arb with an adder datapath model (LAT=1).
module tb_design_40_arb;

  localparam int W = 8, N = 4, LAT = 1, IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   dp_a, dp_b, dp_y;
  logic           dp_start;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_y;
  logic           drain_req, drain_done, busy;

  int tests = 0;
  int fails = 0;

  typedef struct { int id; int y; } exp_t;
  exp_t exp_q[$];

  logic [W-1:0] aq, bq;

  design_40_arb #(.W(W), .N(N), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .dp_a(dp_a), .dp_b(dp_b), .dp_start(dp_start),
    .dp_y(dp_y), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .drain_req(drain_req), .drain_done(drain_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // datapath model: latch operands on start, y = a_q + b_q one cycle later
  always @(posedge clk) if (dp_start) begin aq <= dp_a; bq <= dp_b; end
  assign dp_y = aq + bq;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pop and compare every presented response
  always @(negedge clk) begin
    #2;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp_id", int'(rsp_id), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", int'(rsp_id), e.id);
        chk("rsp_y", int'(rsp_y), e.y);
      end
    end
  end

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic set_default_ops();
    for (int i = 0; i < N; i++) set_ops(i, i + 1, 32 + i);
  endtask

  // drive one cycle and check the grant; push expected response when push=1
  task automatic cyc(input logic [N-1:0] v, input logic d, input logic r,
                     input logic [N-1:0] exp_rdy, input bit push);
    int g;
    @(negedge clk);
    req_valid = v; drain_req = d; rst = r;
    #1;
    chk("req_ready", int'(req_ready), int'(exp_rdy));
    chk("dp_start", int'(dp_start), int'(exp_rdy != 0));
    if (exp_rdy != 0) begin
      g = 0;
      for (int i = 0; i < N; i++) if (exp_rdy[i]) g = i;
      chk("dp_a", int'(dp_a), int'(req_a[g*W +: W]));
      if (push) exp_q.push_back('{id: g, y: (int'(req_a[g*W +: W]) + int'(req_b[g*W +: W])) % 256});
    end
  endtask

  initial begin
    req_valid = '0; drain_req = 1'b0; rst = 1'b1;
    set_default_ops();

    // reset with requests pending
    cyc(4'b1111, 1'b0, 1'b1, 4'b0000, 0);
    cyc(4'b1111, 1'b0, 1'b1, 4'b0000, 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_drain_done", int'(drain_done), 0);

    // all four requesting: 0,1,2,3,0,1,2,3
    for (int k = 0; k < 8; k++) cyc(4'b1111, 1'b0, 1'b0, 4'(1 << (k % 4)), 1);

    // idle: no issue, busy drops once the last tag retires, rr_ptr unchanged
    for (int k = 0; k < 5; k++) begin
      cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 0);
      if (k > 0) chk("idle_busy", int'(busy), 0);
    end
    chk("idle_rr_ptr", int'(dut.rr_ptr), 0);

    // single request from 2: 3+5
    set_ops(2, 3, 5);
    cyc(4'b0100, 1'b0, 1'b0, 4'b0100, 1);
    cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 0);
    chk("single_rr_ptr", int'(dut.rr_ptr), 3);
    set_default_ops();

    // wrap fairness from rr_ptr=3
    cyc(4'b1001, 1'b0, 1'b0, 4'b1000, 1);
    cyc(4'b1001, 1'b0, 1'b0, 4'b0001, 1);
    cyc(4'b1001, 1'b0, 1'b0, 4'b1000, 1);

    // drain with an op in flight from requester 1
    cyc(4'b0010, 1'b0, 1'b0, 4'b0010, 1);
    cyc(4'b1111, 1'b1, 1'b0, 4'b0000, 0);
    cyc(4'b1111, 1'b1, 1'b0, 4'b0000, 0);
    chk("drain_done_t2", int'(drain_done), 1);
    cyc(4'b1111, 1'b1, 1'b0, 4'b0000, 0);
    chk("drain_done_t3", int'(drain_done), 1);
    cyc(4'b1111, 1'b0, 1'b0, 4'b0000, 0);
    cyc(4'b1111, 1'b0, 1'b0, 4'b0100, 1);
    chk("resume_drain_done", int'(drain_done), 0);

    // reset mid-operation: the grant to 0 before reset never responds
    cyc(4'b0001, 1'b0, 1'b0, 4'b0001, 0);
    cyc(4'b1111, 1'b0, 1'b1, 4'b0000, 0);
    chk("midrst_rsp_valid", int'(rsp_valid), 0);
    cyc(4'b1111, 1'b0, 1'b0, 4'b0001, 1);

    cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 0);
    cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 0);
    cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 0);
    chk("end_busy", int'(busy), 0);
    chk("scoreboard_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
